instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Program sequencer directly upstream of the instruction decoder.
- Owns the PC and reads the synchronous instruction memory. Presents opcode and operand fields from a registered instruction register (IR) to the decoder.
- Takes f_wait back from the decoder and stalls issue for the operand-specified number of cycles.
- Runs one program from address 0 to prog_len, then signals done.

Parameters:
- INSTR_WIDTH, 16, instruction word width; opcode = top OPCODE_WIDTH bits, operand = remaining low bits.
- OPCODE_WIDTH, 3, opcode field width; must match the decoder.
- ADDR_WIDTH, 8, instruction memory address width.
- WAIT_WIDTH, 8, low operand bits used as the WAIT cycle count; must be ≤ INSTR_WIDTH-OPCODE_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run from address 0; ignored unless IDLE
- stop  in  1  synchronous abort; returns to IDLE next edge, no done pulse
- prog_len  in  ADDR_WIDTH  address of last instruction; sampled when start is accepted
- imem_rd_en  out  1  memory read strobe
- imem_addr  out  ADDR_WIDTH  memory read address
- imem_rdata  in  INSTR_WIDTH  read data, valid the cycle after imem_rd_en
- f_wait  in  1  from decoder, combinational on opcode
- opcode  out  OPCODE_WIDTH  IR opcode field to decoder
- operand  out  INSTR_WIDTH-OPCODE_WIDTH  IR operand field
- instr_valid  out  1  IR holds an instruction to execute this cycle
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last instruction retires

Behaviour:
- Reset (async, immediate):
  - state=IDLE; pc=0; IR=0; skid buffer empty; wait counter=0.
  - All outputs 0, including mid-run.
- States:
  - IDLE: start → FILL.
  - FILL: primes the pipeline.
  - RUN: streams instructions.
  - WAIT: stalls issue.
  - DONE: one cycle, done=1, → IDLE.
- Cycle n = period after edge n. Start sampled at edge 0:
  - cycle 0: imem_rd_en=1, imem_addr=0.
  - cycle 1: rdata=mem[0]; read of addr 1 issued if prog_len>0.
  - edge 2: IR←mem[0]; cycle 2: instr_valid=1.
- Steady RUN: one instruction per cycle, no bubbles. Reads stop after address prog_len is issued. pc never exceeds prog_len and never wraps.
- imem_rd_en is combinational from state, pc and stall; imem_addr=pc is registered.
- WAIT handling:
  - In the cycle where instr_valid && f_wait, the WAIT instruction is valid for exactly one cycle.
  - Then N=operand[WAIT_WIDTH-1:0] cycles follow with instr_valid=0; opcode/operand hold their last value.
  - Then the next instruction is valid on the following cycle.
  - N=0: no bubble.
  - The in-flight word k+1 arriving during the stall is captured in a 1-entry skid buffer. On resume, IR←skid, and the read for k+2 is timed so that no extra bubble appears.
  - f_wait is ignored whenever instr_valid=0.
- Completion:
  - After the valid cycle of the instruction at prog_len, plus any WAIT cycles it triggers → DONE (done=1, busy=1) → IDLE.
  - If the last instruction is WAIT, done follows its N stall cycles.
- stop:
  - In FILL/RUN/WAIT → IDLE at next edge; instr_valid=0, skid cleared, no done.
  - stop and start in the same cycle while IDLE: stop wins (start ignored).
- start in any state other than IDLE is ignored. A start in the DONE cycle is ignored.
- Widths:
  - pc increments modulo 2^ADDR_WIDTH, but the bound check prevents wrap.
  - The wait counter is WAIT_WIDTH bits and counts down to 0.

Decomposition:
- Shared package (alongside the opcode definitions) holds:
  - the fetch state enum;
  - the INSTR_WIDTH / OPCODE_WIDTH defaults;
  - the WAIT opcode constant, used only by the bench (the block relies on f_wait).
- One sub-module, wait_timer:
  - loadable down-counter of WAIT_WIDTH bits;
  - inputs load, count value; output expired (high when count=0 and loaded).

Test Plan:
- Reset, then start with prog_len=3 over mem = {MOV, SETB, MAC, LDSW} → instr_valid in cycles 2–5 with opcodes in order; done=1 in cycle 6; busy falls in cycle 7; imem_addr never exceeds 3.
- mem = {MOV, WAIT operand=4, SETD, MAC}, prog_len=3, bench models the decoder's f_wait → WAIT valid cycle 3, instr_valid=0 in cycles 4–7, SETD valid cycle 8, MAC valid cycle 9, done in cycle 10.
- WAIT with operand=0 mid-program → no bubble; sequence identical in timing to a non-WAIT instruction.
- Last instruction is WAIT operand=2, prog_len=0 → WAIT valid cycle 2, bubbles in cycles 3–4, done in cycle 5.
- stop asserted in cycle 4 of a prog_len=7 run → IDLE after edge 5, instr_valid=0, no done; a subsequent start reruns from address 0.
- rst asserted asynchronously mid-WAIT, then start pulsed during RUN → all outputs 0 immediately on reset; the start pulsed during RUN is ignored; the next start after completion fetches address 0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_pkg
// Description : Shared definitions for the program sequencer: fetch state
//               encoding, default field widths and opcode constants.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

    localparam int DEF_INSTR_WIDTH  = 16;
    localparam int DEF_OPCODE_WIDTH = 3;

    // Opcode field values shared with the decoder
    localparam logic [2:0] OP_MOV  = 3'd0;
    localparam logic [2:0] OP_SETB = 3'd1;
    localparam logic [2:0] OP_SETD = 3'd2;
    localparam logic [2:0] OP_MAC  = 3'd3;
    localparam logic [2:0] OP_LDSW = 3'd4;
    localparam logic [2:0] OP_WAIT = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_RUN  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : wait_timer
// Description : Loadable down-counter. expired is high in the cycle where a
//               loaded count has reached zero; it then disarms itself.
// Revision    : 1.0 - initial release
// ============================================================================
module wait_timer #(
    parameter int WAIT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WAIT_WIDTH-1:0] load_val,
    output logic                  expired
);

    logic [WAIT_WIDTH-1:0] count;
    logic                  armed;

    // Count down from the loaded value; disarm once zero has been seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            armed <= 1'b0;
        end else if (clear) begin
            count <= '0;
            armed <= 1'b0;
        end else if (load) begin
            count <= load_val;
            armed <= 1'b1;
        end else if (armed) begin
            if (count == '0) begin
                armed <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign expired = armed && (count == '0);

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Program sequencer. Streams instructions 0..prog_len from a
//               synchronous memory into a registered IR, stalls issue for
//               WAIT instructions flagged by the decoder, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int INSTR_WIDTH  = DEF_INSTR_WIDTH,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int ADDR_WIDTH   = 8,
    parameter int WAIT_WIDTH   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            stop,
    input  logic [ADDR_WIDTH-1:0]           prog_len,
    output logic                            imem_rd_en,
    output logic [ADDR_WIDTH-1:0]           imem_addr,
    input  logic [INSTR_WIDTH-1:0]          imem_rdata,
    input  logic                            f_wait,
    output logic [OPCODE_WIDTH-1:0]         opcode,
    output logic [INSTR_WIDTH-OPCODE_WIDTH-1:0] operand,
    output logic                            instr_valid,
    output logic                            busy,
    output logic                            done
);

    localparam int OPERAND_WIDTH = INSTR_WIDTH - OPCODE_WIDTH;

    fetch_state_t           state;
    fetch_state_t           state_next;

    logic [ADDR_WIDTH-1:0]  pc;          // address of the next read
    logic [ADDR_WIDTH-1:0]  last_addr;   // prog_len captured at start
    logic                   reads_done;  // read of last_addr already issued
    logic                   rvalid;      // imem_rdata carries a word this cycle
    logic                   rlast;       // ...and that word is the last one
    logic [INSTR_WIDTH-1:0] ir;
    logic                   ir_last;
    logic [INSTR_WIDTH-1:0] skid;
    logic                   skid_valid;
    logic                   skid_last;
    logic [WAIT_WIDTH-1:0]  wait_n;
    logic                   stall;
    logic                   expired;
    logic                   at_last;
    logic                   rd_issue;
    logic                   timer_load;

    assign instr_valid = (state == ST_RUN);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign wait_n      = ir[WAIT_WIDTH-1:0];
    // A zero-length WAIT behaves like any other instruction
    assign stall       = instr_valid && f_wait && (wait_n != '0);
    assign at_last     = (pc == last_addr);
    assign timer_load  = stall && !stop;

    assign imem_rd_en  = rd_issue;
    assign imem_addr   = pc;
    assign opcode      = ir[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign operand     = ir[OPERAND_WIDTH-1:0];

    // Read strobe: continuous in FILL/RUN, held off while a WAIT is issued,
    // and re-issued in the last stall cycle so the skid word is followed
    // without a bubble
    always_comb begin
        rd_issue = 1'b0;
        case (state)
            ST_FILL: rd_issue = 1'b1;
            ST_RUN:  rd_issue = !stall;
            ST_WAIT: rd_issue = expired;
            default: rd_issue = 1'b0;
        endcase
        if (reads_done) begin
            rd_issue = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (rvalid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (stall) begin
                    state_next = ST_WAIT;
                end else if (ir_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (expired) begin
                    state_next = skid_valid ? ST_RUN : ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Read address sequencing and read-data tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= '0;
            last_addr  <= '0;
            reads_done <= 1'b0;
            rvalid     <= 1'b0;
            rlast      <= 1'b0;
        end else if (state == ST_IDLE) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (start && !stop) begin
                pc         <= '0;
                last_addr  <= prog_len;
                reads_done <= 1'b0;
            end
        end else if (stop || state == ST_DONE) begin
            pc         <= '0;
            reads_done <= 1'b0;
            rvalid     <= 1'b0;
            rlast      <= 1'b0;
        end else begin
            rvalid <= rd_issue;
            rlast  <= rd_issue && at_last;
            if (rd_issue) begin
                // Stop at last_addr rather than stepping past it
                if (at_last) begin
                    reads_done <= 1'b1;
                end else begin
                    pc <= pc + 1'b1;
                end
            end
        end
    end

    // Instruction register and one-entry skid buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir         <= '0;
            ir_last    <= 1'b0;
            skid       <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
        end else if (stop && state != ST_IDLE) begin
            skid_valid <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (rvalid) begin
                        ir      <= imem_rdata;
                        ir_last <= rlast;
                    end
                end
                ST_RUN: begin
                    if (stall) begin
                        // Word already in flight lands here while IR holds
                        skid       <= imem_rdata;
                        skid_valid <= rvalid;
                        skid_last  <= rlast;
                    end else if (!ir_last) begin
                        ir      <= imem_rdata;
                        ir_last <= rlast;
                    end
                end
                ST_WAIT: begin
                    if (expired && skid_valid) begin
                        ir         <= skid;
                        ir_last    <= skid_last;
                        skid_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Load N-1 so that expiry marks the final stall cycle
    wait_timer #(
        .WAIT_WIDTH (WAIT_WIDTH)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (stop),
        .load     (timer_load),
        .load_val (wait_n - 1'b1),
        .expired  (expired)
    );

endmodule
`default_nettype wire
